// File: rtl/uart_pkg.sv
// Shared state encodings and the baud divider helper for the UART core.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  // Rounded pclk cycles per oversample tick, never below 1.
  function automatic int calc_div(input int clock_rate, input int baud, input int os);
    int d;
    d = (clock_rate + (baud * os) / 2) / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample clock-enable generator: one-cycle os_tick every DIV pclk cycles.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic pclk,
  input  logic reset,
  output logic os_tick
);
  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    os_tick = (cnt_q == LAST);
    cnt_d   = os_tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_core.sv
// Full-duplex UART, single pclk domain, tick-enabled TX/RX FSMs.
// Optional parity bit on both directions when UART_PARITY_EN is defined.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 pclk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_line,
  output logic                 tx_busy,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 framing_error,
  input  logic                 parity_odd,
  output logic                 parity_error
);
  localparam int DIV = calc_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [BW-1:0]  LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]  LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [OSW-1:0] OS_LAST   = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_MID    = OSW'(OVERSAMPLE / 2 - 1);

  logic os_tick;
  uart_baud_tick #(.DIV(DIV)) u_tick (.pclk(pclk), .reset(reset), .os_tick(os_tick));

  tx_state_t            tx_state_q, tx_state_d;
  logic [OSW-1:0]       tx_os_q, tx_os_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_bit_end;

  rx_state_t            rx_state_q, rx_state_d;
  logic [OSW-1:0]       rx_os_q, rx_os_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic                 rx_sync_q, rx_s_q, rx_prev_q, rx_mid;
  logic                 rx_done_q, rx_done_d, ferr_q, ferr_d;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d, rx_par_q, rx_par_d, perr_q, perr_d;
`else
  logic                 unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  // tx_line decodes straight from registered state so reset forces it high at once.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_os_d    = tx_os_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    tx_line    = 1'b1;
    tx_bit_end = os_tick && (tx_os_q == OS_LAST);
    if (os_tick) tx_os_d = tx_os_q + OSW'(1);
    case (tx_state_q)
      TX_IDLE: if (tx_start) begin
        tx_state_d = TX_START;
        tx_os_d    = '0;
        tx_shift_d = tx_data;
`ifdef UART_PARITY_EN
        tx_par_d   = ^tx_data ^ parity_odd;
`endif
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = '0;
        end
      end
      TX_DATA: begin
        tx_line = tx_shift_q[0];
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + BW'(1);
          if (tx_bit_q == LAST_BIT) begin
            tx_bit_d = '0;
`ifdef UART_PARITY_EN
            tx_state_d = TX_PARITY;
`else
            tx_state_d = TX_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        tx_line = tx_par_q;
        if (tx_bit_end) tx_state_d = TX_STOP;
      end
`endif
      TX_STOP: if (tx_bit_end) begin
        if (tx_bit_q == LAST_STOP) tx_state_d = TX_IDLE;
        else                       tx_bit_d   = tx_bit_q + BW'(1);
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // RX times everything from the detected start edge; mid-bit is OVERSAMPLE ticks apart.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_os_d    = rx_os_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_done_d  = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_d   = rx_par_q;
    perr_d     = 1'b0;
`endif
    rx_mid = os_tick && (rx_os_q == OS_LAST);
    if (os_tick) rx_os_d = rx_os_q + OSW'(1);
    case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_s_q) begin
        rx_state_d = RX_START;
        rx_os_d    = '0;
      end
      RX_START: if (os_tick && rx_os_q == OS_MID) begin
        rx_os_d    = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_mid) begin
        rx_shift_d = {rx_s_q, rx_shift_q[DATA_BITS-1:1]};
        rx_bit_d   = rx_bit_q + BW'(1);
        if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
          rx_state_d = RX_PARITY;
`else
          rx_state_d = RX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: if (rx_mid) begin
        rx_par_d   = rx_s_q;
        rx_state_d = RX_STOP;
      end
`endif
      RX_STOP: if (rx_mid) begin
        rx_data_d  = rx_shift_q;
        rx_done_d  = 1'b1;
        ferr_d     = !rx_s_q;
`ifdef UART_PARITY_EN
        perr_d     = rx_par_q ^ (^rx_shift_q) ^ parity_odd;
`endif
        // A low stop means break or garbage: re-arm only once the line is idle again.
        rx_state_d = rx_s_q ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: if (rx_s_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_os_q    <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      rx_state_q <= RX_IDLE;
      rx_os_q    <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_sync_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_done_q  <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
      rx_par_q   <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_os_q    <= tx_os_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      rx_state_q <= rx_state_d;
      rx_os_q    <= rx_os_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_sync_q  <= rx_serial;
      rx_s_q     <= rx_sync_q;
      rx_prev_q  <= rx_s_q;
      rx_done_q  <= rx_done_d;
      ferr_q     <= ferr_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
      rx_par_q   <= rx_par_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign tx_busy       = (tx_state_q != TX_IDLE);
  assign rx_data       = rx_data_q;
  assign rx_done       = rx_done_q;
  assign framing_error = ferr_q;
`ifdef UART_PARITY_EN
  assign parity_error  = perr_q;
`else
  assign parity_error  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: TX loops to RX through a mux, expected TX frames and RX
// results are queued at issue time and popped by independent line/output monitors.
module tb_uart_core;
  localparam int BIT_CLKS = 16;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBITS8 = 1 + 8 + PB + 1;
  localparam int BUSY8  = BIT_CLKS * NBITS8;
  localparam int BUSY7  = BIT_CLKS * (1 + 7 + PB + 2);

  typedef struct packed { logic [7:0] data; logic ferr; logic perr; } rx_exp_t;

  logic       pclk = 1'b0, reset = 1'b1;
  logic       tx_start = 1'b0, tx_line, tx_busy;
  logic [7:0] tx_data = 8'h00, rx_data;
  logic       rx_serial, drv_rx = 1'b1, loop_en = 1'b1;
  logic       rx_done, framing_error, parity_odd = 1'b0, parity_error;
  logic       tx_start7 = 1'b0, tx_line7, tx_busy7, rx_done7, ferr7, perr7;
  logic [6:0] tx_data7 = 7'h00, rx_data7;
  logic       tx_mon_en = 1'b1;

  int n_cmp = 0, n_fail = 0, done_cnt = 0;
  rx_exp_t    rxq[$];
  logic [7:0] txq[$];
  logic [6:0] q7[$];

  always #5 pclk = ~pclk;
  assign rx_serial = loop_en ? tx_line : drv_rx;

  uart_core #(.CLOCK_RATE(1600000), .BAUD_RATE(100000), .DATA_BITS(8), .STOP_BITS(1),
              .OVERSAMPLE(16)) u_dut (
    .pclk(pclk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .tx_line(tx_line), .tx_busy(tx_busy), .rx_serial(rx_serial), .rx_data(rx_data),
    .rx_done(rx_done), .framing_error(framing_error), .parity_odd(parity_odd),
    .parity_error(parity_error));

  uart_core #(.CLOCK_RATE(1600000), .BAUD_RATE(100000), .DATA_BITS(7), .STOP_BITS(2),
              .OVERSAMPLE(16)) u_dut7 (
    .pclk(pclk), .reset(reset), .tx_start(tx_start7), .tx_data(tx_data7),
    .tx_line(tx_line7), .tx_busy(tx_busy7), .rx_serial(tx_line7), .rx_data(rx_data7),
    .rx_done(rx_done7), .framing_error(ferr7), .parity_odd(1'b0),
    .parity_error(perr7));

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic rx_exp_t mk(input logic [7:0] d, input logic f, input logic p);
    rx_exp_t e;
    e.data = d; e.ferr = f; e.perr = p;
    return e;
  endfunction

  // Line image of one frame, bit 0 = start bit; unused upper bits stay 1.
  function automatic logic [15:0] frame8(input logic [7:0] d, input logic odd);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
    if (PB == 1) f[9] = ^d ^ odd;
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic rx_bit(input logic v);
    drv_rx = v;
    tick(BIT_CLKS);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic par_flip, input logic stop);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(d[i]);
    if (PB == 1) rx_bit(^d ^ parity_odd ^ par_flip);
    rx_bit(stop);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (tx_busy && n < 1000) begin n++; tick(1); end
    if (tx_busy) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: tx_busy still 1 after %0d cycles, required 0", nm, n);
    end
  endtask

  task automatic tx_send(input logic [7:0] d);
    tx_data = d; tx_start = 1'b1;
    @(posedge pclk); #1 tx_start = 1'b0;
    check("tx_busy_after_accept", 32'(tx_busy), 32'd1);
  endtask

  task automatic xfer(input logic [7:0] d);
    txq.push_back(d);
    rxq.push_back(mk(d, 1'b0, 1'b0));
    tx_send(d);
    wait_idle("xfer_idle");
    tick(20);
  endtask

  task automatic tx7(input logic [6:0] d);
    int n;
    q7.push_back(d);
    tx_data7 = d; tx_start7 = 1'b1;
    @(posedge pclk); #1 tx_start7 = 1'b0;
    n = 0;
    while (tx_busy7 && n < 1000) begin n++; tick(1); end
    check("t7_busy_len", 32'(n), 32'(BUSY7));
    tick(20);
  endtask

  initial begin : tx_mon
    logic prev;
    logic [15:0] got;
    logic [7:0] d;
    prev = 1'b1;
    forever begin
      @(negedge pclk);
      if (tx_mon_en && prev && !tx_line) begin
        got = '1;
        repeat (BIT_CLKS / 2) @(negedge pclk);
        got[0] = tx_line;
        for (int i = 1; i < NBITS8; i++) begin
          repeat (BIT_CLKS) @(negedge pclk);
          got[i] = tx_line;
        end
        if (txq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL tx_unexpected_frame: line bits %0h, no frame expected", got);
        end else begin
          d = txq.pop_front();
          check("tx_frame_bits", 32'(got), 32'(frame8(d, parity_odd)));
        end
      end
      prev = tx_line;
    end
  end

  initial begin : rx_mon
    rx_exp_t e;
    forever begin
      @(negedge pclk);
      if (rx_done) begin
        done_cnt++;
        if (rxq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rx_unexpected_done: data %0h ferr %0b perr %0b, none expected",
                   rx_data, framing_error, parity_error);
        end else begin
          e = rxq.pop_front();
          check("rx_data_ferr_perr", 32'({rx_data, framing_error, parity_error}), 32'(e));
        end
        @(negedge pclk);
        check("rx_done_pulse_width", 32'(rx_done), 32'd0);
      end
    end
  end

  initial begin : rx7_mon
    logic [6:0] e7;
    forever begin
      @(negedge pclk);
      if (rx_done7) begin
        if (q7.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rx7_unexpected_done: data %0h, none expected", rx_data7);
        end else begin
          e7 = q7.pop_front();
          check("rx7_data_ferr_perr", 32'({rx_data7, ferr7, perr7}), 32'({e7, 2'b00}));
        end
      end
    end
  end

  initial begin : watchdog
    #(60000 * 10);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n, g, d0;
    tick(3);
    check("rst_tx_line", 32'(tx_line), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_done", 32'(rx_done), 32'd0);
    check("rst_framing_error", 32'(framing_error), 32'd0);
    check("rst_parity_error", 32'(parity_error), 32'd0);
    reset = 1'b0;
    tick(5);

    // 1: single loopback frame
    xfer(8'hA5);

    // 2: tx_start held, back-to-back 00 then FF, second request ignored while busy
    txq.push_back(8'h00); txq.push_back(8'hFF);
    rxq.push_back(mk(8'h00, 1'b0, 1'b0)); rxq.push_back(mk(8'hFF, 1'b0, 1'b0));
    tx_data = 8'h00; tx_start = 1'b1;
    @(posedge pclk); #1 tx_data = 8'hFF;
    n = 0;
    while (tx_busy && n < 1000) begin n++; tick(1); end
    check("t2_busy_len_frame1", 32'(n), 32'(BUSY8));
    g = 0;
    while (!tx_busy && g < 50) begin g++; tick(1); end
    check("t2_idle_gap_cycles", 32'(g), 32'd1);
    tx_start = 1'b0;
    n = 0;
    while (tx_busy && n < 1000) begin n++; tick(1); end
    check("t2_busy_len_frame2", 32'(n), 32'(BUSY8));
    tick(40);
    check("t2_no_third_frame", 32'(tx_busy), 32'd0);

    // 3: short glitch is a false start, then a real frame
    loop_en = 1'b0; drv_rx = 1'b1; tick(5);
    d0 = done_cnt;
    drv_rx = 1'b0; tick(5); drv_rx = 1'b1; tick(3 * BIT_CLKS);
    check("t3_false_start_no_done", 32'(done_cnt), 32'(d0));
    rxq.push_back(mk(8'h3C, 1'b0, 1'b0));
    rx_frame(8'h3C, 1'b0, 1'b1);
    tick(2 * BIT_CLKS);

    // 4: bad stop bit then line held low; one frame only until idle + new start
    d0 = done_cnt;
    rxq.push_back(mk(8'h81, 1'b1, 1'b0));
    rx_frame(8'h81, 1'b0, 1'b0);
    drv_rx = 1'b0; tick(40 * BIT_CLKS);
    check("t4_one_done_in_break", 32'(done_cnt), 32'(d0 + 1));
    drv_rx = 1'b1; tick(3 * BIT_CLKS);
    check("t4_no_done_on_release", 32'(done_cnt), 32'(d0 + 1));
    rxq.push_back(mk(8'h96, 1'b0, 1'b0));
    rx_frame(8'h96, 1'b0, 1'b1);
    tick(2 * BIT_CLKS);
    rxq.push_back(mk(8'h00, 1'b1, 1'b0));
    drv_rx = 1'b0; tick(20 * BIT_CLKS);
    drv_rx = 1'b1; tick(2 * BIT_CLKS);

`ifdef UART_PARITY_EN
    // 5: parity generation and a flipped parity bit on RX
    loop_en = 1'b1; tick(5);
    xfer(8'h07);
    loop_en = 1'b0; tick(5);
    rxq.push_back(mk(8'h07, 1'b0, 1'b1));
    rx_frame(8'h07, 1'b1, 1'b1);
    tick(2 * BIT_CLKS);
    loop_en = 1'b1; parity_odd = 1'b1; tick(5);
    xfer(8'h07);
    parity_odd = 1'b0;
`endif

    // 6: async reset in the middle of TX and RX data bits
    loop_en = 1'b1; tick(5);
    tx_mon_en = 1'b0;
    d0 = done_cnt;
    tx_send(8'hC3);
    tick(60);
    check("t6_line_low_before_reset", 32'(tx_line), 32'd0);
    @(posedge pclk); #2 reset = 1'b1;
    #1;
    check("t6_tx_line_in_reset", 32'(tx_line), 32'd1);
    check("t6_tx_busy_in_reset", 32'(tx_busy), 32'd0);
    tick(3);
    reset = 1'b0;
    tick(3 * BIT_CLKS);
    check("t6_no_done_after_reset", 32'(done_cnt), 32'(d0));
    tx_mon_en = 1'b1;
    xfer(8'h5A);

    // 7: 7 data bits, 2 stop bits
    tx7(7'h5A);
    tx7(7'h2B);

    tick(100);
    check("end_rx_queue_drained", 32'(rxq.size()), 32'd0);
    check("end_tx_queue_drained", 32'(txq.size()), 32'd0);
    check("end_rx7_queue_drained", 32'(q7.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
